// File: rtl/usb_tx_packet_encoder_if.sv
// Transmit-side handshake and line bundle for the USB packet encoder.
// The master drives packet start and payload; the slave (encoder) drives the line and status.
interface usb_tx_packet_encoder_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       d_plus_out;
  logic       d_minus_out;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output tx_start, tx_pid, tx_data, data_valid, data_last,
    input  data_ready, d_plus_out, d_minus_out, busy, done, underrun
  );

  modport slave (
    input  tx_start, tx_pid, tx_data, data_valid, data_last,
    output data_ready, d_plus_out, d_minus_out, busy, done, underrun
  );
endinterface

// File: rtl/usb_tx_packet_encoder.sv
// USB packet serializer: SYNC, PID, payload, optional CRC16 (USB_TX_CRC16_EN), EOP; NRZI with bit stuffing.
// First line bit one clock after tx_start; bytes pulled by data_ready in the final bit of each byte, absence aborts.
module usb_tx_packet_encoder (
  input  logic                   tb_clk,
  input  logic                   tb_n_rst,
  usb_tx_packet_encoder_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA,
`ifdef USB_TX_CRC16_EN
    CRC,
`endif
    EOP_SE0, EOP_J
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [15:0] sr_q, sr_d;
  logic [2:0]  ones_q, ones_d;
  logic        dp_q, dp_d, dm_q, dm_d;
  logic [3:0]  pid_q, pid_d;
  logic [7:0]  nxt_q, nxt_d;
  logic        nxt_vld_q, nxt_vld_d, nxt_last_q, nxt_last_d;
  logic        cur_last_q, cur_last_d, ur_q, ur_d;
  logic        done_q, done_d, underrun_q, underrun_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction
`endif

  logic       boundary, handshake, ready, accept, have_next, next_last;
  logic [7:0] next_byte;
  logic [3:0] last_idx;
  logic       emit_en, emit_b, load_go, eop_go;

  assign boundary  = (bit_cnt_q == 3'd7);
  assign handshake = (pid_q[1:0] == 2'b10);
  assign ready     = (bit_idx_q == 4'd7) && !nxt_vld_q &&
                     ((state_q == PID && !handshake) || (state_q == DATA && !cur_last_q));
  assign accept    = bus.data_valid && ready;
  assign have_next = nxt_vld_q || accept;
  assign next_byte = nxt_vld_q ? nxt_q : bus.tx_data;
  assign next_last = nxt_vld_q ? nxt_last_q : bus.data_last;
`ifdef USB_TX_CRC16_EN
  assign last_idx  = (state_q == CRC) ? 4'd15 : 4'd7;
`else
  assign last_idx  = 4'd7;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    sr_d       = sr_q;
    ones_d     = ones_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    pid_d      = pid_q;
    nxt_d      = nxt_q;
    nxt_vld_d  = nxt_vld_q;
    nxt_last_d = nxt_last_q;
    cur_last_d = cur_last_q;
    ur_d       = ur_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_d      = crc_q;
`endif
    emit_en    = 1'b0;
    emit_b     = 1'b0;
    load_go    = 1'b0;
    eop_go     = 1'b0;

    if (accept) begin
      nxt_d      = bus.tx_data;
      nxt_vld_d  = 1'b1;
      nxt_last_d = bus.data_last;
    end
    if (state_q != IDLE) bit_cnt_d = bit_cnt_q + 3'd1;

    case (state_q)
      IDLE: if (bus.tx_start) begin
        state_d    = SYNC;
        bit_cnt_d  = 3'd0;
        bit_idx_d  = 4'd0;
        sr_d       = 16'h0080;
        pid_d      = bus.tx_pid;
        nxt_vld_d  = 1'b0;
        cur_last_d = 1'b0;
        ur_d       = 1'b0;
        emit_en    = 1'b1;
`ifdef USB_TX_CRC16_EN
        crc_d      = 16'hFFFF;
`endif
      end
      EOP_SE0: if (boundary) begin
        if (bit_idx_q == 4'd0) bit_idx_d = 4'd1;
        else begin
          state_d = EOP_J;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
        end
      end
      EOP_J: if (boundary) begin
        state_d = IDLE;
        done_d  = !ur_q;
      end
      default: if (boundary) begin
        // A pending stuff bit always wins, so it also lands before EOP.
        if (ones_q == 3'd6) begin
          emit_en = 1'b1;
        end else if (bit_idx_q != last_idx) begin
          bit_idx_d = bit_idx_q + 4'd1;
          emit_en   = 1'b1;
          emit_b    = sr_q[bit_idx_q + 4'd1];
`ifdef USB_TX_CRC16_EN
          if (state_q == DATA) crc_d = crc_step(crc_q, emit_b);
`endif
        end else begin
          case (state_q)
            SYNC: begin
              state_d   = PID;
              sr_d      = {8'h00, ~pid_q, pid_q};
              bit_idx_d = 4'd0;
              emit_en   = 1'b1;
              emit_b    = pid_q[0];
            end
            PID: begin
              if (handshake) eop_go = 1'b1;
              else if (have_next) load_go = 1'b1;
              else begin
                eop_go     = 1'b1;
                underrun_d = 1'b1;
                ur_d       = 1'b1;
              end
            end
            DATA: begin
              if (cur_last_q) begin
`ifdef USB_TX_CRC16_EN
                if (pid_q[1:0] == 2'b11) begin
                  state_d   = CRC;
                  sr_d      = ~crc_q;
                  bit_idx_d = 4'd0;
                  emit_en   = 1'b1;
                  emit_b    = ~crc_q[0];
                end else eop_go = 1'b1;
`else
                eop_go = 1'b1;
`endif
              end else if (have_next) load_go = 1'b1;
              else begin
                eop_go     = 1'b1;
                underrun_d = 1'b1;
                ur_d       = 1'b1;
              end
            end
            default: eop_go = 1'b1;
          endcase
        end
      end
    endcase

    if (load_go) begin
      state_d    = DATA;
      sr_d       = {8'h00, next_byte};
      bit_idx_d  = 4'd0;
      cur_last_d = next_last;
      nxt_vld_d  = 1'b0;
      emit_en    = 1'b1;
      emit_b     = next_byte[0];
`ifdef USB_TX_CRC16_EN
      crc_d      = crc_step(crc_q, next_byte[0]);
`endif
    end
    if (eop_go) begin
      state_d   = EOP_SE0;
      bit_idx_d = 4'd0;
      dp_d      = 1'b0;
      dm_d      = 1'b0;
    end
    // NRZI: a 0 toggles the line, a 1 holds it.
    if (emit_en) begin
      dp_d   = emit_b ? dp_q : ~dp_q;
      dm_d   = ~dp_d;
      ones_d = emit_b ? (ones_q + 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      bit_idx_q  <= 4'd0;
      sr_q       <= 16'h0000;
      ones_q     <= 3'd0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      pid_q      <= 4'd0;
      nxt_q      <= 8'h00;
      nxt_vld_q  <= 1'b0;
      nxt_last_q <= 1'b0;
      cur_last_q <= 1'b0;
      ur_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      sr_q       <= sr_d;
      ones_q     <= ones_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      pid_q      <= pid_d;
      nxt_q      <= nxt_d;
      nxt_vld_q  <= nxt_vld_d;
      nxt_last_q <= nxt_last_d;
      cur_last_q <= cur_last_d;
      ur_q       <= ur_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef USB_TX_CRC16_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign bus.data_ready  = ready;
  assign bus.d_plus_out  = dp_q;
  assign bus.d_minus_out = dm_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_usb_tx_packet_encoder.sv
// Bench for usb_tx_packet_encoder: builds each packet's expected line as a list of bit-time symbols
// (J/K/SE0) from the framing, NRZI and stuffing rules, then compares the DUT every clock.
module tb_usb_tx_packet_encoder;
  logic tb_clk = 1'b0;
  logic tb_n_rst;
  always #5 tb_clk = ~tb_clk;

  usb_tx_packet_encoder_if bus();
  usb_tx_packet_encoder dut (.tb_clk(tb_clk), .tb_n_rst(tb_n_rst), .bus(bus));

  localparam logic [1:0] SJ = 2'b10, SK = 2'b01, SSE0 = 2'b00;

  int n_checks = 0, n_fail = 0, cur_k = -1;
  logic [1:0]  sym_q[$];
  bit          rdy_q[$];
  logic [7:0]  pay[$];
  int          se0_idx, nb, ones;
  bit          lvl, exp_ur;
  logic [15:0] crc;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, cur_k, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // One transmitted bit; a stuff bit inherits the ready-window tag of the bit before it.
  task automatic push_bit(input bit b, input bit tag);
    lvl = b ? lvl : ~lvl;
    sym_q.push_back(lvl ? SJ : SK);
    rdy_q.push_back(tag);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      lvl = ~lvl;
      sym_q.push_back(lvl ? SJ : SK);
      rdy_q.push_back(tag);
      ones = 0;
    end
  endtask

  task automatic push_byte(input logic [7:0] v, input bit win);
    for (int i = 0; i < 8; i++) push_bit(v[i], win && (i == 7));
  endtask

  task automatic build(input logic [3:0] pid, input bit with_last);
    bit hs;
    sym_q.delete(); rdy_q.delete();
    lvl = 1'b1; ones = 0; crc = 16'hFFFF;
    hs = (pid[1:0] == 2'b10);
    push_byte(8'h80, 1'b0);
    push_byte({~pid, pid}, !hs);
    if (!hs) begin
      for (int i = 0; i < pay.size(); i++) begin
        push_byte(pay[i], !(with_last && (i == pay.size() - 1)));
        for (int j = 0; j < 8; j++) crc = crc_step(crc, pay[i][j]);
      end
`ifdef USB_TX_CRC16_EN
      if (with_last && pid[1:0] == 2'b11)
        for (int j = 0; j < 16; j++) push_bit(~crc[j], 1'b0);
`endif
    end
    se0_idx = sym_q.size();
    sym_q.push_back(SSE0); rdy_q.push_back(1'b0);
    sym_q.push_back(SSE0); rdy_q.push_back(1'b0);
    sym_q.push_back(SJ);   rdy_q.push_back(1'b0);
    nb = sym_q.size();
    exp_ur = !hs && !with_last;
  endtask

  function automatic logic [15:0] pack8(input int base);
    logic [15:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[13:0], sym_q[base + i]};
    return r;
  endfunction

  task automatic run_pkt(input logic [3:0] pid, input bit with_last, input int delay,
                         input int busy_at, input int rst_at);
    int idx = 0, wc = 0, limit;
    bit acc = 0, prev_win = 0, cur_win, exp_rdy;
    logic [1:0] exp_line;
    limit = 8 * nb + 2;
    @(negedge tb_clk);
    bus.tx_start = 1'b1; bus.tx_pid = pid;
    @(posedge tb_clk); #1;
    bus.tx_start = 1'b0;
    for (int k = 0; k <= limit; k++) begin
      cur_k = k;
      cur_win = (k < 8 * nb) && rdy_q[k / 8];
      if (!cur_win) begin wc = 0; acc = 0; end
      else if (prev_win) wc++;
      else begin wc = 0; acc = 0; end
      prev_win = cur_win;
      exp_rdy = cur_win && !acc;
      bus.data_valid = (idx < pay.size()) && ((delay == 0) || (cur_win && wc >= delay));
      bus.tx_data    = (idx < pay.size()) ? pay[idx] : 8'h00;
      bus.data_last  = with_last && (idx == pay.size() - 1);
      bus.tx_start   = (k == busy_at);
      if (k == busy_at) bus.tx_pid = 4'b0010;
      @(negedge tb_clk);
      if (k == rst_at) begin
        tb_n_rst = 1'b0;
        #1;
        check("rst_line", {bus.d_plus_out, bus.d_minus_out}, SJ);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.data_ready, 1'b0);
        break;
      end
      exp_line = (k < 8 * nb) ? sym_q[k / 8] : SJ;
      check("line", {bus.d_plus_out, bus.d_minus_out}, exp_line);
      check("busy", bus.busy, k < 8 * nb);
      check("done", bus.done, !exp_ur && (k == 8 * nb));
      check("underrun", bus.underrun, exp_ur && (k == 8 * se0_idx));
      check("data_ready", bus.data_ready, exp_rdy);
      if (bus.data_valid && exp_rdy) begin acc = 1; idx++; end
      @(posedge tb_clk); #1;
    end
    bus.data_valid = 1'b0; bus.data_last = 1'b0; bus.tx_start = 1'b0;
  endtask

  initial begin
    tb_n_rst = 1'b0;
    bus.tx_start = 1'b0; bus.tx_pid = 4'd0; bus.tx_data = 8'h00;
    bus.data_valid = 1'b0; bus.data_last = 1'b0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check("reset_line", {bus.d_plus_out, bus.d_minus_out}, SJ);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_ready", bus.data_ready, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_underrun", bus.underrun, 1'b0);
    tb_n_rst = 1'b1;

    // ACK handshake
    pay.delete();
    build(4'b0010, 1'b1);
    check("ack_done_clock", 8 * nb, 152);
    check("ack_sync_syms", pack8(0), 16'h6665);
    check("ack_pid_syms", pack8(8), 16'hA695);
    run_pkt(4'b0010, 1'b1, 0, -1, -1);

    // DATA0, single 0xFF: one stuffed bit
    pay = '{8'hFF};
    build(4'b0011, 1'b1);
    check("stuff_bits", se0_idx, 25);
    run_pkt(4'b0011, 1'b1, 0, -1, -1);

    // DATA1 with no byte offered during the PID final bit
    pay.delete();
    build(4'b1011, 1'b0);
    check("ur_se0_at", se0_idx, 16);
    run_pkt(4'b1011, 1'b0, 0, -1, -1);

    // DATA0 00 01 02 03, valid arriving late in each ready window
    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    build(4'b0011, 1'b1);
`ifndef USB_TX_CRC16_EN
    check("nocrc_len", se0_idx, 48);
`endif
    run_pkt(4'b0011, 1'b1, 3, -1, -1);

    // Underrun after one data byte
    pay = '{8'h12};
    build(4'b0011, 1'b0);
    run_pkt(4'b0011, 1'b0, 0, -1, -1);

    // tx_start mid-DATA is ignored
    pay = '{8'hA5, 8'h3C};
    build(4'b1011, 1'b1);
    run_pkt(4'b1011, 1'b1, 0, 150, -1);

    // Reset mid-DATA
    pay = '{8'h55, 8'hAA, 8'h0F};
    build(4'b0011, 1'b1);
    run_pkt(4'b0011, 1'b1, 0, -1, 170);
    @(posedge tb_clk); @(posedge tb_clk);
    @(negedge tb_clk);
    tb_n_rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge tb_clk);
      cur_k = i;
      check("post_rst_line", {bus.d_plus_out, bus.d_minus_out}, SJ);
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_done", bus.done, 1'b0);
    end

    // NAK after recovery
    pay.delete();
    build(4'b1010, 1'b1);
    run_pkt(4'b1010, 1'b1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_tx_packet_encoder.md
USB_TX_PACKET_ENCODER -- requirements
Module: usb_tx_packet_encoder

Interface
REQ-001 SHALL have port tb_clk  input  1  system clock.
REQ-002 SHALL have port tb_n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port tx_start  input  1  one-cycle pulse that starts a packet.
REQ-004 SHALL have port tx_pid  input  4  packet PID, sampled when tx_start is accepted.
REQ-005 SHALL have port tx_data  input  8  payload byte.
REQ-006 SHALL have port data_valid  input  1  tx_data is valid.
REQ-007 SHALL have port data_last  input  1  the current byte is the final payload byte.
REQ-008 SHALL have port data_ready  output  1  encoder accepts a byte when data_valid&&data_ready.
REQ-009 SHALL have ports d_plus_out and d_minus_out  output  1 each  USB line pair.
REQ-010 SHALL have port busy  output  1  a packet is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a packet completes.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a packet is aborted for missing data.

Function
REQ-013 SHALL use a bit time of 8 tb_clk cycles, with the line changing only on bit-counter wrap to 0.
REQ-014 SHALL implement FSM states IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
REQ-015 SHALL accept tx_start only in IDLE, entering SYNC; the first sync bit appears on the line one tb_clk later.
REQ-016 SHALL ignore tx_start while busy.
REQ-017 SHALL send SYNC as byte 0x80, LSB first, so the line from J reads K J K J K J K K.
REQ-018 SHALL send the PID byte as {~tx_pid, tx_pid}, LSB first.
REQ-019 SHALL go from PID to EOP_SE0 when tx_pid[1:0]==2'b10 (handshake); otherwise it SHALL go to DATA.
REQ-020 SHALL send all bytes LSB first.
REQ-021 SHALL NRZI-encode the line: a 0 bit toggles J/K, a 1 bit holds it; J is d_plus=1, d_minus=0.
REQ-022 SHALL bit-stuff: after six consecutive transmitted 1s, insert one 0 bit (a toggle).
- The ones counter SHALL clear on any transmitted 0.
- Sync bits SHALL count toward the ones counter.
- A stuff bit owed after the final data/CRC bit SHALL be sent before EOP.
REQ-023 SHALL assert data_ready throughout the final bit time of the PID byte or current data byte (data_ready=0 if data_last is already accepted).
REQ-024 SHALL treat no acceptance by that bit-time end as underrun: skip remaining bytes, go to EOP_SE0, pulse underrun for 1 cycle, and suppress done.
REQ-025 SHALL, once data_last is accepted and that byte is sent, go to CRC (macro on) or EOP_SE0 (macro off).
REQ-026 SHALL drive EOP_SE0 as d_plus=0, d_minus=0 for 2 bit times.
REQ-027 SHALL drive EOP_J as J for 1 bit time.
REQ-028 SHALL, at the end of EOP_J, return to IDLE, pulse done, and deassert busy in the same cycle.
REQ-029 SHALL hold busy high from the cycle after tx_start acceptance through the last cycle of EOP_J.

Reset
REQ-030 SHALL, on tb_n_rst low (including mid-packet), immediately return the FSM to IDLE with d_plus_out=1, d_minus_out=0, and busy/data_ready/done/underrun=0.
REQ-031 SHALL clear the bit counter, ones counter, and CRC register on reset, and SHALL not resume a packet after reset release.

Configuration
REQ-032 SHALL, with USB_TX_CRC16_EN defined and tx_pid[1:0]==2'b11, append CRC16 after the data bytes.
- Polynomial 0x8005, init 0xFFFF, over the data bits as sent before stuffing.
- The result SHALL be complemented and sent LSB first, with bit-stuffing applied.
REQ-033 SHALL, without USB_TX_CRC16_EN, omit the CRC state; the sender supplies CRC as ordinary data bytes.

Verification
REQ-034 SHALL cover ACK: tx_pid=0010 -> line K J K J K J K K; PID byte 0xD2 NRZI-coded; SE0 for 16 clocks; J for 8 clocks; done at clock 152 after start.
REQ-035 SHALL cover stuffing: DATA0 (0011) with one byte 0xFF last, macro off -> exactly one stuffed 0 after the 6th consecutive 1; frame is 8+8+9 bits, then EOP.
REQ-036 SHALL cover underrun: DATA1 (1011) with data_valid=0 during the PID final bit time -> EOP_SE0 follows the PID; underrun=1 for 1 cycle; done stays 0.
REQ-037 SHALL cover start while busy: tx_start pulsed mid-DATA -> no effect on the line; one done only.
REQ-038 SHALL cover reset mid-DATA: tb_n_rst=0 -> line is J and busy=0 in the same cycle; the line stays J after release.
REQ-039 SHALL cover CRC: with USB_TX_CRC16_EN, DATA0 with bytes 0x00 0x01 0x02 0x03 -> 16 CRC bits matching a bit-serial reference model, then EOP; without the macro, EOP follows 0x03 directly.
